// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 bus arbitration slice.
package c64_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRACE,
    DMA,
    RELEASE
  } arb_state_t;

  localparam int unsigned C64_GRACE_CYCLES = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// 6510 bus-steal arbiter between video/cartridge DMA and the CPU wrapper.
// Define CPU_ARB_WRITE_GRACE_EN to let writes complete during grace and to enable steal_cnt.
module cpu_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES = C64_GRACE_CYCLES,
  parameter int unsigned STEAL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cyc_en,
  input  logic                   vic_req,
  input  logic                   ext_dma,
  input  logic                   cpu_we,
  output logic                   ba,
  output logic                   rdy,
  output logic                   aec,
  output logic [STEAL_CNT_W-1:0] steal_cnt,
  input  logic                   steal_clr
);

  localparam logic [1:0] GCNT_INIT = 2'(GRACE_CYCLES - 1);

  arb_state_t state;
  logic [1:0] gcnt;
  logic       req;

  assign req = vic_req | ext_dma;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gcnt  <= '0;
      ba    <= 1'b1;
    end else if (cyc_en) begin
      case (state)
        IDLE: begin
          if (req) begin
            state <= GRACE;
            gcnt  <= GCNT_INIT;
            ba    <= 1'b0;
          end
        end
        GRACE: begin
          if (!req) begin
            state <= IDLE;
            ba    <= 1'b1;
          end else if (ext_dma || (gcnt == '0)) begin
            state <= DMA;
          end else begin
            gcnt <= gcnt - 2'd1;
          end
        end
        DMA: begin
          if (!req) begin
            state <= RELEASE;
            ba    <= 1'b1;
          end
        end
        RELEASE: begin
          if (req) begin
            state <= GRACE;
            gcnt  <= GCNT_INIT;
            ba    <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ba    <= 1'b1;
        end
      endcase
    end
  end

  // CPU-facing strobes decode state only, so request glitches never reach RDY/AEC.
  always_comb begin
    aec = 1'b1;
    rdy = 1'b1;
    case (state)
      GRACE: begin
`ifdef CPU_ARB_WRITE_GRACE_EN
        rdy = cpu_we;
`else
        rdy = 1'b0;
`endif
      end
      DMA: begin
        aec = 1'b0;
        rdy = 1'b0;
      end
      default: begin
        aec = 1'b1;
        rdy = 1'b1;
      end
    endcase
  end

`ifdef CPU_ARB_WRITE_GRACE_EN
  sat_counter #(
    .W(STEAL_CNT_W)
  ) u_steal_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cyc_en & steal_clr),
    .inc    (cyc_en && (state == DMA)),
    .cnt    (steal_cnt)
  );
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, steal_clr, cpu_we};
  assign steal_cnt     = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Randomised and directed bench for cpu_bus_arbiter against a run-length reference model.
module tb_cpu_bus_arbiter;

  localparam int G = 3;
  localparam int W = 16;
`ifdef CPU_ARB_WRITE_GRACE_EN
  localparam bit WG = 1'b1;
`else
  localparam bit WG = 1'b0;
`endif
  localparam int SAT_LEN = WG ? 65600 : 64;
  localparam int unsigned CNT_MAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cyc_en = 1'b0;
  logic vic_req = 1'b0;
  logic ext_dma = 1'b0;
  logic cpu_we = 1'b0;
  logic steal_clr = 1'b0;
  logic ba, rdy, aec;
  logic [W-1:0] steal_cnt;

  int checks = 0;
  int failures = 0;

  // Model: length of the current unbroken request run, whether the bus has been stolen in it.
  int          m_run;
  bit          m_stolen;
  int unsigned m_cnt;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(
    .GRACE_CYCLES(G),
    .STEAL_CNT_W (W)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cyc_en   (cyc_en),
    .vic_req  (vic_req),
    .ext_dma  (ext_dma),
    .cpu_we   (cpu_we),
    .ba       (ba),
    .rdy      (rdy),
    .aec      (aec),
    .steal_cnt(steal_cnt),
    .steal_clr(steal_clr)
  );

  function automatic logic exp_ba();
    return logic'(m_run == 0);
  endfunction

  function automatic logic exp_aec();
    return logic'(!m_stolen);
  endfunction

  function automatic logic exp_rdy();
    if (m_run == 0) return 1'b1;
    if (m_stolen) return 1'b0;
    return WG ? cpu_we : 1'b0;
  endfunction

  function automatic logic [W-1:0] exp_cnt();
    return WG ? W'(m_cnt) : '0;
  endfunction

  task automatic model_reset();
    m_run = 0;
    m_stolen = 1'b0;
    m_cnt = 0;
  endtask

  // One CPU cycle ending in a cyc_en pulse; returns at the negedge after the pulse.
  task automatic step(input logic vr, input logic ed, input logic we, input logic clr);
    vic_req = vr;
    ext_dma = ed;
    cpu_we = we;
    steal_clr = clr;
    cyc_en = 1'b1;
    @(negedge clk);
    cyc_en = 1'b0;
    if (m_stolen && m_cnt < CNT_MAX) m_cnt++;
    if (clr) m_cnt = 0;
    if (!(vr | ed)) begin
      m_run = 0;
      m_stolen = 1'b0;
    end else begin
      if (m_run > 0 && !m_stolen && (ed || m_run >= G)) m_stolen = 1'b1;
      m_run++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL reset_ba got=%b exp=1", ba); end
    checks++; if (aec !== 1'b1) begin failures++; $display("FAIL reset_aec got=%b exp=1", aec); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", rdy); end
    checks++; if (steal_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", steal_cnt); end
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (aec !== 1'b0) begin failures++; $display("FAIL reset_pre_dma_aec got=%b exp=0", aec); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (aec !== 1'b1) begin failures++; $display("FAIL reset_async_aec got=%b exp=1", aec); end
    checks++; if (ba !== 1'b1) begin failures++; $display("FAIL reset_async_ba got=%b exp=1", ba); end
    checks++; if (rdy !== 1'b1) begin failures++; $display("FAIL reset_async_rdy got=%b exp=1", rdy); end
    vic_req = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_badline();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 58; n++) begin
      logic vr, eb, ea;
      vr = (n >= 10 && n <= 52);
      eb = !(n >= 11 && n <= 53);
      ea = !(n >= 14 && n <= 53);
      cpu_we = 1'b0;
      #1;
      checks++; if (ba !== eb) begin failures++; $display("FAIL badline_ba cyc=%0d got=%b exp=%b", n, ba, eb); end
      checks++; if (aec !== ea) begin failures++; $display("FAIL badline_aec cyc=%0d got=%b exp=%b", n, aec, ea); end
      checks++; if (rdy !== eb) begin failures++; $display("FAIL badline_rdy cyc=%0d got=%b exp=%b", n, rdy, eb); end
      step(vr, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (steal_cnt !== (WG ? W'(40) : W'(0))) begin
      failures++; $display("FAIL badline_cnt got=%0d exp=%0d", steal_cnt, WG ? 40 : 0);
    end
  endtask

  task automatic test_write_grace();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 18; n++) begin
      logic vr, we, er;
      vr = (n >= 10 && n <= 15);
      we = (n == 11 || n == 12);
      cpu_we = we;
      #1;
      if (n >= 11 && n <= 13) begin
        er = WG && (n != 13);
        checks++; if (rdy !== er) begin failures++; $display("FAIL wgrace_rdy cyc=%0d got=%b exp=%b", n, rdy, er); end
        checks++; if (aec !== 1'b1) begin failures++; $display("FAIL wgrace_aec cyc=%0d got=%b exp=1", n, aec); end
      end
      if (n == 14) begin
        checks++; if (aec !== 1'b0) begin failures++; $display("FAIL wgrace_dma_aec got=%b exp=0", aec); end
      end
      step(vr, 1'b0, we, 1'b0);
    end
  endtask

  task automatic test_short_req();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 8; n++) begin
      logic eb;
      eb = !(n == 3 || n == 4);
      cpu_we = 1'b0;
      #1;
      checks++; if (ba !== eb) begin failures++; $display("FAIL short_ba cyc=%0d got=%b exp=%b", n, ba, eb); end
      checks++; if (aec !== 1'b1) begin failures++; $display("FAIL short_aec cyc=%0d got=%b exp=1", n, aec); end
      step(n == 2 || n == 3, 1'b0, 1'b0, 1'b0);
    end
    checks++; if (steal_cnt !== '0) begin failures++; $display("FAIL short_cnt got=%0d exp=0", steal_cnt); end
  endtask

  task automatic test_cart_dma();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n <= 35; n++) begin
      logic eb, ea;
      eb = !(n >= 11 && n <= 30);
      ea = !(n >= 13 && n <= 30);
      cpu_we = 1'b0;
      #1;
      checks++; if (ba !== eb) begin failures++; $display("FAIL cart_ba cyc=%0d got=%b exp=%b", n, ba, eb); end
      checks++; if (aec !== ea) begin failures++; $display("FAIL cart_aec cyc=%0d got=%b exp=%b", n, aec, ea); end
      step(n >= 10 && n <= 11, n >= 12 && n <= 29, 1'b0, 1'b0);
    end
    checks++;
    if (steal_cnt !== (WG ? W'(18) : W'(0))) begin
      failures++; $display("FAIL cart_cnt got=%0d exp=%0d", steal_cnt, WG ? 18 : 0);
    end
  endtask

  task automatic test_random();
    logic vr = 1'b0;
    logic ed = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic we, clr;
      if ($urandom_range(0, 7) == 0) vr = ~vr;
      if ($urandom_range(0, 15) == 0) ed = ~ed;
      we = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 39) == 0);
      cpu_we = we;
      #1;
      checks++; if (ba !== exp_ba()) begin failures++; $display("FAIL rand_ba it=%0d got=%b exp=%b", i, ba, exp_ba()); end
      checks++; if (aec !== exp_aec()) begin failures++; $display("FAIL rand_aec it=%0d got=%b exp=%b", i, aec, exp_aec()); end
      checks++; if (rdy !== exp_rdy()) begin failures++; $display("FAIL rand_rdy it=%0d got=%b exp=%b", i, rdy, exp_rdy()); end
      checks++; if (steal_cnt !== exp_cnt()) begin failures++; $display("FAIL rand_cnt it=%0d got=%0d exp=%0d", i, steal_cnt, exp_cnt()); end
      cpu_we = ~we;
      #1;
      checks++; if (rdy !== exp_rdy()) begin failures++; $display("FAIL rand_rdy_we it=%0d got=%b exp=%b", i, rdy, exp_rdy()); end
      cpu_we = we;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      #1;
      checks++; if (ba !== exp_ba()) begin failures++; $display("FAIL rand_hold_ba it=%0d got=%b exp=%b", i, ba, exp_ba()); end
      checks++; if (aec !== exp_aec()) begin failures++; $display("FAIL rand_hold_aec it=%0d got=%b exp=%b", i, aec, exp_aec()); end
      step(vr, ed, we, clr);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < SAT_LEN; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (steal_cnt !== (WG ? W'(CNT_MAX) : W'(0))) begin
      failures++; $display("FAIL sat_cnt got=%0h exp=%0h", steal_cnt, WG ? CNT_MAX : 0);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (steal_cnt !== exp_cnt()) begin failures++; $display("FAIL sat_hold got=%0h exp=%0h", steal_cnt, exp_cnt()); end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (steal_cnt !== '0) begin failures++; $display("FAIL sat_clr got=%0h exp=0", steal_cnt); end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_badline();
    test_write_grace();
    test_short_req();
    test_cart_dma();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
